// File: rtl/main_ram_arbiter_pkg.sv
// Shared address map, requester ids, FSM state codes and the SDRAM command
// bundle used by the main RAM arbiter and its round-robin picker.
package main_ram_arbiter_pkg;

    localparam logic [4:0] BSRAM_PREFIX_DEF = 5'b10000;
    localparam logic       ROM_PREFIX       = 1'b0;

    typedef enum logic [1:0] {
        REQ_LD  = 2'd0,
        REQ_ROM = 2'd1,
        REQ_BS  = 2'd2
    } req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [24:0] addr;
        logic        rd;
        logic        wr;
        logic        word;
        logic [15:0] din;
    } mem_cmd_t;

endpackage

// File: rtl/main_ram_arbiter_rr_pick.sv
// Two-way round-robin pick between ROM and BSRAM; the side not granted last wins a tie.
// Latency: combinational pick, last-grant register updates on the take strobe.
// Backpressure: none; the caller only strobes take when it actually grants.
module main_ram_arbiter_rr_pick
    import main_ram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic rom_pend,
    input  logic bs_pend,
    input  logic take,
    output logic pick_rom,
    output logic pick_bs
);

    req_id_t last_grant_q;

    always_comb begin
        pick_bs  = bs_pend && (!rom_pend || (last_grant_q != REQ_BS));
        pick_rom = rom_pend && !pick_bs;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= REQ_ROM;
        end else if (take && (pick_bs || pick_rom)) begin
            last_grant_q <= pick_bs ? REQ_BS : REQ_ROM;
        end
    end

endmodule

// File: rtl/main_ram_arbiter.sv
// Registered scheduler sharing one SDRAM port between loader writes, ROM reads and BSRAM byte access.
// Latency: 4 cycles req->ack with a 1-cycle SDRAM busy; next grant the cycle after DONE.
// Backpressure: requests are held levels; mem_busy stalls in BUSY, ISSUE gives up after BUSY_TIMEOUT.
module main_ram_arbiter
    import main_ram_arbiter_pkg::*;
#(
    parameter int         BUSY_TIMEOUT = 16,
    parameter logic [4:0] BSRAM_PREFIX = BSRAM_PREFIX_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_active,
    input  logic        ld_req,
    input  logic [24:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_ack,
    input  logic        rom_req,
    input  logic [23:0] rom_addr,
    input  logic        rom_word,
    output logic        rom_ack,
    output logic [15:0] rom_q,
    input  logic        bs_req,
    input  logic        bs_we,
    input  logic [19:0] bs_addr,
    input  logic [7:0]  bs_d,
    output logic        bs_ack,
    output logic [7:0]  bs_q,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_word,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_busy,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_t     state_q, state_d;
    req_id_t    owner_q, owner_d;
    mem_cmd_t   cmd_q, cmd_d;
    logic       is_wr_q, is_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       terr_d;
    logic       ld_ack_d, rom_ack_d, bs_ack_d;
    logic [15:0] rom_q_d;
    logic [7:0] bs_q_d;
    logic       rr_take;
    logic       finish;
    logic       pick_rom, pick_bs;

    main_ram_arbiter_rr_pick u_rr_pick (
        .clk      (clk),
        .reset_n  (reset_n),
        .rom_pend (rom_req),
        .bs_pend  (bs_req),
        .take     (rr_take),
        .pick_rom (pick_rom),
        .pick_bs  (pick_bs)
    );

    assign mem_addr = cmd_q.addr;
    assign mem_rd   = cmd_q.rd;
    assign mem_wr   = cmd_q.wr;
    assign mem_word = cmd_q.word;
    assign mem_din  = cmd_q.din;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;
        terr_d    = timeout_err;
        ld_ack_d  = 1'b0;
        rom_ack_d = 1'b0;
        bs_ack_d  = 1'b0;
        rom_q_d   = rom_q;
        bs_q_d    = bs_q;
        rr_take   = 1'b0;
        finish    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Loader has the memory to itself while loading; otherwise it is ignored.
                if (load_active) begin
                    if (ld_req) begin
                        owner_d = REQ_LD;
                        cmd_d   = '{addr: ld_addr, rd: 1'b0, wr: 1'b1, word: 1'b1, din: ld_data};
                        is_wr_d = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else if (pick_bs) begin
                    owner_d = REQ_BS;
                    cmd_d   = '{addr: {BSRAM_PREFIX, bs_addr}, rd: !bs_we, wr: bs_we,
                                word: 1'b0, din: {bs_d, bs_d}};
                    is_wr_d = bs_we;
                    rr_take = 1'b1;
                    state_d = ST_ISSUE;
                end else if (pick_rom) begin
                    owner_d = REQ_ROM;
                    cmd_d   = '{addr: {ROM_PREFIX, rom_addr}, rd: 1'b1, wr: 1'b0,
                                word: rom_word, din: 16'h0000};
                    is_wr_d = 1'b0;
                    rr_take = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_busy) begin
                    cmd_d.rd = 1'b0;
                    cmd_d.wr = 1'b0;
                    state_d  = ST_BUSY;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    cmd_d.rd = 1'b0;
                    cmd_d.wr = 1'b0;
                    terr_d   = 1'b1;
                    finish   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (!mem_busy) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ack and read data become visible together for the single DONE cycle, so a
        // requester dropping req on ack is already low when IDLE arbitrates again.
        if (finish) begin
            case (owner_q)
                REQ_LD: ld_ack_d = 1'b1;
                REQ_ROM: begin
                    rom_ack_d = 1'b1;
                    rom_q_d   = mem_dout;
                end
                REQ_BS: begin
                    bs_ack_d = 1'b1;
                    if (!is_wr_q) begin
                        bs_q_d = mem_dout[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= REQ_LD;
            cmd_q       <= '0;
            is_wr_q     <= 1'b0;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
            ld_ack      <= 1'b0;
            rom_ack     <= 1'b0;
            bs_ack      <= 1'b0;
            rom_q       <= '0;
            bs_q        <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cmd_q       <= cmd_d;
            is_wr_q     <= is_wr_d;
            cnt_q       <= cnt_d;
            timeout_err <= terr_d;
            ld_ack      <= ld_ack_d;
            rom_ack     <= rom_ack_d;
            bs_ack      <= bs_ack_d;
            rom_q       <= rom_q_d;
            bs_q        <= bs_q_d;
        end
    end

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Directed bench for main_ram_arbiter with a small behavioural SDRAM responder.
module tb_main_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_active;
    logic        ld_req;
    logic [24:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_ack;
    logic        rom_req;
    logic [23:0] rom_addr;
    logic        rom_word;
    logic        rom_ack;
    logic [15:0] rom_q;
    logic        bs_req;
    logic        bs_we;
    logic [19:0] bs_addr;
    logic [7:0]  bs_d;
    logic        bs_ack;
    logic [7:0]  bs_q;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_word;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    main_ram_arbiter #(.BUSY_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_active (load_active),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ack      (ld_ack),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_word    (rom_word),
        .rom_ack     (rom_ack),
        .rom_q       (rom_q),
        .bs_req      (bs_req),
        .bs_we       (bs_we),
        .bs_addr     (bs_addr),
        .bs_d        (bs_d),
        .bs_ack      (bs_ack),
        .bs_q        (bs_q),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_word    (mem_word),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_busy    (mem_busy),
        .timeout_err (timeout_err)
    );

    // SDRAM responder: accepts a command when idle, stays busy sd_lat cycles.
    logic        sd_en;
    int          sd_lat;
    logic [15:0] forced_dout;
    logic [15:0] model_dout = 16'h0000;
    logic        model_busy;
    int          bcnt;
    logic [15:0] sd_mem [logic [24:0]];
    int          issue_cnt = 0;
    int          cyc = 0;
    logic [24:0] last_addr = '0;
    logic        last_rd = 1'b0;
    logic        last_wr = 1'b0;
    logic        last_word = 1'b0;
    logic [15:0] last_din = '0;
    logic        is_bs_q[$];
    int          stamp_q[$];

    assign mem_busy = model_busy;
    assign mem_dout = sd_en ? model_dout : forced_dout;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_busy <= 1'b0;
            bcnt       <= 0;
            sd_mem[25'h000FFC0] = 16'h1234;
        end else if (model_busy) begin
            if (bcnt <= 1) model_busy <= 1'b0;
            bcnt <= bcnt - 1;
        end else if (sd_en && (mem_rd || mem_wr)) begin
            model_busy <= 1'b1;
            bcnt       <= sd_lat;
            issue_cnt  <= issue_cnt + 1;
            last_addr  <= mem_addr;
            last_rd    <= mem_rd;
            last_wr    <= mem_wr;
            last_word  <= mem_word;
            last_din   <= mem_din;
            is_bs_q.push_back(mem_addr[24:20] == 5'b10000);
            stamp_q.push_back(cyc);
            if (mem_wr) sd_mem[mem_addr] = mem_din;
            else model_dout <= sd_mem.exists(mem_addr) ? sd_mem[mem_addr] : 16'hDEAD;
        end
    end

    int n_ld = 0, n_rom = 0, n_bs = 0, n_multi = 0;
    always @(negedge clk) begin
        n_ld  <= n_ld + int'(ld_ack);
        n_rom <= n_rom + int'(rom_ack);
        n_bs  <= n_bs + int'(bs_ack);
        if (int'(ld_ack) + int'(rom_ack) + int'(bs_ack) > 1) n_multi <= n_multi + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int which, input int budget, output int cycles);
        logic hit;
        hit = 1'b0;
        cycles = 0;
        while (!hit && cycles < budget) begin
            @(negedge clk);
            cycles++;
            hit = (which == 0) ? ld_ack : (which == 1) ? rom_ack : bs_ack;
        end
        chk("ack_arrived", hit, 1'b1);
    endtask

    initial begin
        #300000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        int lat;
        int rdhi;
        int base;
        int r0;
        logic [5:0] order;

        reset_n = 1'b0;
        load_active = 0; ld_req = 0; ld_addr = '0; ld_data = '0;
        rom_req = 0; rom_addr = '0; rom_word = 0;
        bs_req = 0; bs_we = 0; bs_addr = '0; bs_d = '0;
        sd_en = 1; sd_lat = 1; forced_dout = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ld_ack, rom_ack, bs_ack, mem_rd, mem_wr, mem_word, timeout_err,
                              mem_addr, mem_din, rom_q, bs_q}, '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_cmd", {mem_rd, mem_wr}, 2'b00);

        // Loader write while loading; a pending ROM request must be ignored.
        load_active = 1; ld_addr = 25'h0000100; ld_data = 16'hBEEF; ld_req = 1;
        rom_req = 1; rom_addr = 24'h000100; rom_word = 1;
        wait_ack(0, 40, lat);
        ld_req = 0;
        chk("ld_latency", lat, 4);
        chk("ld_cmd", {last_wr, last_rd, last_word, last_addr, last_din},
            {1'b1, 1'b0, 1'b1, 25'h0000100, 16'hBEEF});
        repeat (8) @(negedge clk);
        chk("ld_ack_once", n_ld, 1);
        chk("rom_ignored_while_loading", {issue_cnt, n_rom}, {32'd1, 32'd0});

        // ROM word read; a loader request outside load mode must be ignored.
        rom_req = 0; load_active = 0;
        @(negedge clk);
        rom_req = 1; rom_addr = 24'h00FFC0; rom_word = 1; ld_req = 1;
        wait_ack(1, 40, lat);
        rom_req = 0; ld_req = 0;
        chk("rom_latency", lat, 4);
        chk("rom_addr", last_addr, 25'h000FFC0);
        chk("rom_cmd", {last_rd, last_wr, last_word}, 3'b101);
        chk("rom_q", rom_q, 16'h1234);
        @(negedge clk);
        rom_req = 1; rom_addr = 24'h000100; rom_word = 0;
        wait_ack(1, 40, lat);
        rom_req = 0;
        chk("rom_q_readback_ld", rom_q, 16'hBEEF);
        chk("rom_byte_cmd", {last_rd, last_wr, last_word}, 3'b100);
        repeat (4) @(negedge clk);
        chk("ack_counts_after_rom", {n_ld, n_rom}, {32'd1, 32'd2});

        // BSRAM write then read-back.
        bs_req = 1; bs_we = 1; bs_addr = 20'h00010; bs_d = 8'h5A;
        wait_ack(2, 40, lat);
        bs_req = 0;
        chk("bs_wr_cmd", {last_wr, last_rd, last_word, last_addr, last_din},
            {1'b1, 1'b0, 1'b0, 25'h1000010, 16'h5A5A});
        chk("bs_q_untouched_by_write", bs_q, 8'h00);
        @(negedge clk);
        bs_req = 1; bs_we = 0;
        wait_ack(2, 40, lat);
        bs_req = 0;
        chk("bs_rd_q", bs_q, 8'h5A);
        chk("bs_rd_cmd", {last_rd, last_wr, last_addr}, {1'b1, 1'b0, 25'h1000010});
        chk("rom_q_held", rom_q, 16'hBEEF);

        // Reset while the SDRAM reports busy.
        sd_lat = 20;
        @(negedge clk);
        bs_req = 1; bs_we = 0; bs_addr = 20'h00020;
        lat = 0;
        while (!mem_busy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_seen", mem_busy, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_busy_outputs", {ld_ack, rom_ack, bs_ack, mem_rd, mem_wr, mem_word, timeout_err,
                                       mem_addr, mem_din, rom_q, bs_q}, '0);
        bs_req = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sd_lat = 1;
        repeat (6) @(negedge clk);
        chk("no_stale_ack", {n_ld, n_rom, n_bs}, {32'd1, 32'd2, 32'd2});
        chk("no_restart_after_reset", {issue_cnt, 31'd0, mem_rd}, {32'd6, 32'd0});

        // ROM and BSRAM held together: grants alternate starting with BSRAM.
        rom_addr = 24'h00FFC0; rom_word = 1; bs_addr = 20'h00010; bs_we = 0;
        rom_req = 1; bs_req = 1;
        base = is_bs_q.size();
        lat = 0;
        while (issue_cnt < 12 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        rom_req = 0; bs_req = 0;
        repeat (20) @(negedge clk);
        chk("rr_grant_count", issue_cnt >= 12, 1'b1);
        order = '0;
        for (int i = 0; i < 6; i++) begin
            if (base + i < is_bs_q.size()) order[5 - i] = is_bs_q[base + i];
        end
        chk("rr_order", order, 6'b101010);
        chk("rr_back_to_back_gap", stamp_q[base + 1] - stamp_q[base], 5);
        chk("one_ack_per_cycle", n_multi, 0);
        chk("acks_match_issues", n_ld + n_rom + n_bs, issue_cnt - 1);
        chk("rr_read_data", {rom_q, bs_q}, {16'h1234, 8'h5A});

        // SDRAM never goes busy: ISSUE times out after 16 cycles.
        sd_en = 0; forced_dout = 16'hC0DE;
        r0 = n_rom;
        rom_req = 1; rom_addr = 24'h000200; rom_word = 1;
        rdhi = 0; lat = 0;
        while (!rom_ack && lat < 60) begin
            @(negedge clk);
            lat++;
            if (mem_rd) rdhi++;
            if (lat == 10) chk("no_err_before_timeout", timeout_err, 1'b0);
        end
        rom_req = 0;
        chk("timeout_ack_seen", rom_ack, 1'b1);
        chk("timeout_issue_cycles", rdhi, 16);
        chk("timeout_latency", lat, 17);
        chk("timeout_err_set", timeout_err, 1'b1);
        chk("timeout_rom_q", rom_q, 16'hC0DE);
        repeat (10) @(negedge clk);
        chk("timeout_single_ack", n_rom - r0, 1);
        chk("timeout_err_sticky", timeout_err, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
